// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for a 5-stage RISC-V pipeline: EX-stage bypass selects,
// load-use stall sequencing, data-memory freeze and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
  parameter int NUM_SRC  = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*AW-1:0]  rs_id,
  input  logic [NUM_SRC*AW-1:0]  rs_ex,
  input  logic [AW-1:0]          rd_ex,
  input  logic                   memread_ex,
  input  logic                   regwrite_ex,
  input  logic [AW-1:0]          rd_mem,
  input  logic                   regwrite_mem,
  input  logic [AW-1:0]          rd_wb,
  input  logic                   regwrite_wb,
  input  logic                   mem_busy,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NUM_SRC-1:0] id_match;
  logic            hz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AW-1:0] rs;
    logic [1:0]    sel;
    assign rs = rs_ex[i*AW +: AW];
    // MEM holds the youngest result, so it beats WB; x0 is hardwired zero
    always_comb begin
      sel = 2'b00;
      if (!rst && rs != '0) begin
        if (regwrite_mem && rd_mem == rs)     sel = 2'b10;
        else if (regwrite_wb && rd_wb == rs)  sel = 2'b01;
      end
    end
    assign fwd_sel[2*i +: 2] = sel;
    assign id_match[i] = (rs_id[i*AW +: AW] == rd_ex);
  end

  assign hz = memread_ex & regwrite_ex & (rd_ex != '0) & (|id_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM_WAIT with memory ready behaves exactly like RUN, so they share the decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy)
          state_nxt = MEM_WAIT;
        else if (hz && LOAD_LAT > 1) begin
          state_nxt = LU_STALL;
          cnt_nxt   = CW'(LOAD_LAT - 1);
        end else
          state_nxt = RUN;
      end
      LU_STALL: begin
        if (!mem_busy) begin
          if (cnt == CW'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else
            cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (!rst) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_busy)
            stall = 1'b1;
          else if (hz) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end
        LU_STALL: begin
          stall  = 1'b1;
          bubble = !mem_busy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
